// File: rtl/fifo_rd_stream.sv
// Drains a pop/empty FIFO with one-cycle read latency into a valid/ready stream.
// A two-entry skid buffer plus an in-flight flag keeps full throughput without losing words.
module fifo_rd_stream #(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          fifo_empty_i,
  output logic          fifo_pop_o,
  input  logic [DW-1:0] fifo_data_i,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic [DW-1:0] m_data_o,
  output logic [1:0]    level_o
);

  logic [DW-1:0] r_mem [2];
  logic          r_rdIdx;
  logic          r_wrIdx;
  logic          r_inflight;
  logic [1:0]    r_count;
  logic [DW-1:0] r_mData;

  logic          w_handshake;
  logic          w_capture;
  logic          w_headLoad;
  logic [2:0]    w_occupancy;
  logic [DW-1:0] w_nextHead;

  assign m_valid_o = (r_count != 2'd0);
  assign m_data_o  = r_mData;
  assign level_o   = r_count;

  // The output register is loaded with whatever becomes the head next cycle;
  // it keeps its old value when the buffer drains so m_data_o holds.
  always_comb begin
    w_handshake = m_valid_o & m_ready_i;
    w_capture   = r_inflight;
    w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_handshake};
    fifo_pop_o  = ~rst_i & ~fifo_empty_i & (w_occupancy < 3'd2);
    w_nextHead  = fifo_data_i;
    w_headLoad  = 1'b0;
    if (w_handshake) begin
      if (r_count == 2'd2) begin
        w_nextHead = r_mem[~r_rdIdx];
        w_headLoad = 1'b1;
      end else begin
        w_headLoad = w_capture;
      end
    end else if (r_count == 2'd0) begin
      w_headLoad = w_capture;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_rdIdx    <= 1'b0;
      r_wrIdx    <= 1'b0;
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
      r_mData    <= '0;
    end else begin
      r_inflight <= fifo_pop_o & ~fifo_empty_i;
      if (w_capture) begin
        r_mem[r_wrIdx] <= fifo_data_i;
        r_wrIdx        <= ~r_wrIdx;
      end
      if (w_handshake) begin
        r_rdIdx <= ~r_rdIdx;
      end
      r_count <= r_count + {1'b0, w_capture} - {1'b0, w_handshake};
      if (w_headLoad) begin
        r_mData <= w_nextHead;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: a behavioural FIFO source feeds the DUT
// and a scoreboard of loaded words is compared against every stream handshake.
module tb_fifo_rd_stream;

  localparam int DW = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          fifo_empty_i;
  logic          fifo_pop_o;
  logic [DW-1:0] fifo_data_i;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [DW-1:0] m_data_o;
  logic [1:0]    level_o;

  fifo_rd_stream #(.DW(DW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .fifo_empty_i(fifo_empty_i),
    .fifo_pop_o  (fifo_pop_o),
    .fifo_data_i (fifo_data_i),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_data_o    (m_data_o),
    .level_o     (level_o)
  );

  always #5 clk_i = ~clk_i;

  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] fifoQ[$];
  logic [DW-1:0] sbQ[$];
  int            popTotal = 0;
  int            deliverTotal = 0;
  int            cycle = 0;
  logic          inflightModel = 1'b0;
  logic          prevStall = 1'b0;
  logic [DW-1:0] prevData = '0;
  logic          obsPop, obsHs, obsValid;
  logic [DW-1:0] obsData;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic loadWord(input logic [DW-1:0] w);
    fifoQ.push_back(w);
    sbQ.push_back(w);
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, then
  // advance the FIFO model just after the rising edge.
  task automatic applyStimulus(input logic ready, input logic gapIn);
    int sum;
    m_ready_i    = ready;
    fifo_empty_i = gapIn || (fifoQ.size() == 0);
    @(negedge clk_i);
    obsPop   = fifo_pop_o & ~fifo_empty_i;
    obsValid = m_valid_o;
    obsHs    = m_valid_o & m_ready_i;
    obsData  = m_data_o;
    sum = int'(level_o) + int'(inflightModel);
    checkOutput("invariant", 32'(sum <= 2), 32'd1);
    checkOutput("valid_vs_level", 32'(m_valid_o), 32'(level_o != 2'd0));
    if (prevStall) begin
      checkOutput("hold_valid", 32'(m_valid_o), 32'd1);
      checkOutput("hold_data", 32'(m_data_o), 32'(prevData));
    end
    if (obsHs) begin
      checkOutput("sb_nonempty", 32'(sbQ.size() != 0), 32'd1);
      if (sbQ.size() != 0) checkOutput("sb_data", 32'(m_data_o), 32'(sbQ.pop_front()));
      deliverTotal++;
    end
    prevStall = m_valid_o & ~m_ready_i;
    prevData  = m_data_o;
    @(posedge clk_i);
    #1;
    if (obsPop) begin
      fifo_data_i = fifoQ.pop_front();
      popTotal++;
    end
    inflightModel = obsPop;
    cycle++;
  endtask

  // Popped-but-undelivered words are lost on reset, so drop them from the scoreboard.
  task automatic assertReset(input int holdCycles);
    rst_i = 1'b1;
    #1;
    checkOutput("rst_pop", 32'(fifo_pop_o), 32'd0);
    checkOutput("rst_valid", 32'(m_valid_o), 32'd0);
    checkOutput("rst_level", 32'(level_o), 32'd0);
    checkOutput("rst_data", 32'(m_data_o), 32'd0);
    while (deliverTotal < popTotal) begin
      if (sbQ.size() != 0) void'(sbQ.pop_front());
      deliverTotal++;
    end
    inflightModel = 1'b0;
    prevStall = 1'b0;
    for (int i = 0; i < holdCycles; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("rst_hold_pop", 32'(fifo_pop_o), 32'd0);
    rst_i = 1'b0;
  endtask

  initial begin
    int firstPop, firstValid, lastValid, validCount, startCycle, pops, budget;
    rst_i = 1'b1;
    m_ready_i = 1'b0;
    fifo_empty_i = 1'b1;
    fifo_data_i = '0;
    for (int i = 1; i <= 8; i++) loadWord(DW'(i));
    assertReset(2);

    // Streaming with ready held high
    firstPop = -1; firstValid = -1; lastValid = -1; validCount = 0;
    startCycle = cycle;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0);
      if (obsPop && firstPop < 0) firstPop = cycle - 1;
      if (obsValid) begin
        if (firstValid < 0) firstValid = cycle - 1;
        lastValid = cycle - 1;
        validCount++;
      end
    end
    checkOutput("first_pop_cycle", 32'(firstPop), 32'(startCycle));
    checkOutput("pop_to_valid", 32'(firstValid - firstPop), 32'd2);
    checkOutput("stream_count", 32'(validCount), 32'd8);
    checkOutput("stream_span", 32'(lastValid - firstValid + 1), 32'd8);
    checkOutput("stream_drained", 32'(sbQ.size()), 32'd0);

    // Backpressure
    for (int i = 0; i < 4; i++) loadWord(8'h11 + DW'(i));
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0);
      if (obsPop) pops++;
    end
    checkOutput("bp_pops", 32'(pops), 32'd2);
    checkOutput("bp_level", 32'(level_o), 32'd2);
    checkOutput("bp_data", 32'(m_data_o), 32'h11);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("bp_drained", 32'(sbQ.size()), 32'd0);
    checkOutput("bp_fifo_empty", 32'(fifoQ.size()), 32'd0);

    // Capture and handshake in the same cycle
    loadWord(8'h21);
    loadWord(8'h22);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("sim_level_pre", 32'(level_o), 32'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("sim_hs", 32'(obsHs), 32'd1);
    checkOutput("sim_level_post", 32'(level_o), 32'd1);
    checkOutput("sim_data_post", 32'(m_data_o), 32'h22);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);

    // Empty FIFO
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'($urandom_range(1, 0)), 1'b0);
      checkOutput("empty_pop", 32'(obsPop), 32'd0);
      checkOutput("empty_valid", 32'(m_valid_o), 32'd0);
      checkOutput("empty_level", 32'(level_o), 32'd0);
    end

    // Random ready and random empty gaps
    for (int i = 0; i < 1000; i++) loadWord(DW'($urandom));
    budget = 0;
    while (sbQ.size() != 0 && budget < 20000) begin
      applyStimulus(1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0));
      budget++;
    end
    checkOutput("random_drained", 32'(sbQ.size()), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);

    // Reset with one word buffered and one in flight
    for (int i = 0; i < 6; i++) loadWord(8'h31 + DW'(i));
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("mid_level", 32'(level_o), 32'd1);
    checkOutput("mid_inflight", 32'(inflightModel), 32'd1);
    assertReset(2);
    budget = 0;
    obsHs = 1'b0;
    while (!obsHs && budget < 20) begin
      applyStimulus(1'b1, 1'b0);
      budget++;
    end
    checkOutput("post_reset_hs", 32'(obsHs), 32'd1);
    checkOutput("post_reset_word", 32'(obsData), 32'h33);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("post_reset_drained", 32'(sbQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
